// File: rtl/ntt_unswap.sv
// ntt_unswap: undoes the 2x2 transpose applied by ntt_swap.
//
// An input group is an even beat (a0,a1) followed, after any number of idle cycles, by an
// odd beat (b0,b1). The group leaves as two registered beats: (a0,b0) one cycle after the
// odd beat, then (a1,b1) one cycle later. A new even beat may arrive in the same cycle as
// the second output beat, so the block sustains one beat per cycle.
//
// Ports:
//   clk        - clock, all state updates on posedge
//   rst_n      - asynchronous reset, active-low
//   i_clear    - synchronous clear: drops any half group, forces even phase
//   i_valid    - qualifies i_data0/i_data1 as one input beat
//   i_data0/1  - input beat words
//   o_valid    - qualifies o_data0/o_data1
//   o_data0/1  - output beat words, held while o_valid=0
//   o_phase    - 0 = expecting even beat, 1 = expecting odd beat
//   o_grp_cnt  - number of completed groups (odd beats accepted), wraps

module ntt_unswap #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] i_data0,
   input  logic [DATA_WIDTH-1:0] i_data1,
   output logic                  o_valid,
   output logic [DATA_WIDTH-1:0] o_data0,
   output logic [DATA_WIDTH-1:0] o_data1,
   output logic                  o_phase,
   output logic [CNT_WIDTH-1:0]  o_grp_cnt
);

   localparam logic PH_EVEN = 1'b0;
   localparam logic PH_ODD  = 1'b1;

   logic                  r_phase;
   logic [DATA_WIDTH-1:0] r_hold_a0;
   logic [DATA_WIDTH-1:0] r_hold_a1;
   logic [DATA_WIDTH-1:0] r_hold_b1;
   logic                  r_pend;
   logic                  r_valid;
   logic [DATA_WIDTH-1:0] r_data0;
   logic [DATA_WIDTH-1:0] r_data1;
   logic [CNT_WIDTH-1:0]  r_grp_cnt;

   logic                  w_phase_d;
   logic [DATA_WIDTH-1:0] w_hold_a0_d;
   logic [DATA_WIDTH-1:0] w_hold_a1_d;
   logic [DATA_WIDTH-1:0] w_hold_b1_d;
   logic                  w_pend_d;
   logic                  w_valid_d;
   logic [DATA_WIDTH-1:0] w_data0_d;
   logic [DATA_WIDTH-1:0] w_data1_d;
   logic [CNT_WIDTH-1:0]  w_grp_cnt_d;

   logic w_accept;
   logic w_even_acc;
   logic w_odd_acc;

   // Clear has priority: the beat presented alongside it is dropped.
   assign w_accept   = i_valid & ~i_clear;
   assign w_even_acc = w_accept & (r_phase == PH_EVEN);
   assign w_odd_acc  = w_accept & (r_phase == PH_ODD);

   always_comb begin
      w_phase_d   = r_phase;
      w_hold_a0_d = r_hold_a0;
      w_hold_a1_d = r_hold_a1;
      w_hold_b1_d = r_hold_b1;
      w_pend_d    = r_pend;
      w_valid_d   = 1'b0;
      w_data0_d   = r_data0;
      w_data1_d   = r_data1;
      w_grp_cnt_d = r_grp_cnt;

      // Second output beat of the previous group goes out regardless of clear or a new
      // even beat; it reads the pre-edge hold_a1, so a same-edge capture cannot corrupt it.
      if (r_pend) begin
         w_data0_d = r_hold_a1;
         w_data1_d = r_hold_b1;
         w_valid_d = 1'b1;
         w_pend_d  = 1'b0;
      end

      if (i_clear) begin
         w_phase_d = PH_EVEN;
      end else if (w_even_acc) begin
         w_hold_a0_d = i_data0;
         w_hold_a1_d = i_data1;
         w_phase_d   = PH_ODD;
      end else if (w_odd_acc) begin
         // r_pend is never set in ODD, so this cannot collide with the block above.
         w_data0_d   = r_hold_a0;
         w_data1_d   = i_data0;
         w_valid_d   = 1'b1;
         w_hold_b1_d = i_data1;
         w_pend_d    = 1'b1;
         w_phase_d   = PH_EVEN;
         w_grp_cnt_d = r_grp_cnt + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase   <= PH_EVEN;
         r_hold_a0 <= '0;
         r_hold_a1 <= '0;
         r_hold_b1 <= '0;
         r_pend    <= 1'b0;
         r_valid   <= 1'b0;
         r_data0   <= '0;
         r_data1   <= '0;
         r_grp_cnt <= '0;
      end else begin
         r_phase   <= w_phase_d;
         r_hold_a0 <= w_hold_a0_d;
         r_hold_a1 <= w_hold_a1_d;
         r_hold_b1 <= w_hold_b1_d;
         r_pend    <= w_pend_d;
         r_valid   <= w_valid_d;
         r_data0   <= w_data0_d;
         r_data1   <= w_data1_d;
         r_grp_cnt <= w_grp_cnt_d;
      end
   end

   assign o_valid   = r_valid;
   assign o_data0   = r_data0;
   assign o_data1   = r_data1;
   assign o_phase   = r_phase;
   assign o_grp_cnt = r_grp_cnt;

endmodule

// File: tb/tb_ntt_unswap.sv
// Testbench for ntt_unswap: directed scenarios plus randomized traffic, all checked against
// a stream-level reference (groups pushed as output pairs into a queue, one popped per cycle).

module tb_ntt_unswap;

   localparam int unsigned DW = 64;
   localparam int unsigned CW = 2;

   typedef struct packed {
      logic [DW-1:0] w0;
      logic [DW-1:0] w1;
   } pair_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          i_clear = 1'b0;
   logic          i_valid = 1'b0;
   logic [DW-1:0] i_data0 = '0;
   logic [DW-1:0] i_data1 = '0;
   logic          o_valid;
   logic [DW-1:0] o_data0;
   logic [DW-1:0] o_data1;
   logic          o_phase;
   logic [CW-1:0] o_grp_cnt;

   ntt_unswap #(
      .DATA_WIDTH (DW),
      .CNT_WIDTH  (CW)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (i_clear),
      .i_valid   (i_valid),
      .i_data0   (i_data0),
      .i_data1   (i_data1),
      .o_valid   (o_valid),
      .o_data0   (o_data0),
      .o_data1   (o_data1),
      .o_phase   (o_phase),
      .o_grp_cnt (o_grp_cnt)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference state: pending output pairs, held even beat, completed groups, last output.
   pair_t       exp_q[$];
   logic        m_half = 1'b0;
   pair_t       m_even = '0;
   int unsigned m_groups = 0;
   pair_t       m_last = '0;
   logic        m_valid = 1'b0;

   int          vcount;     // o_valid cycles observed
   pair_t       out_q[$];   // observed output stream

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_half   = 1'b0;
      m_even   = '0;
      m_groups = 0;
      m_last   = '0;
      m_valid  = 1'b0;
   endtask

   // Apply the block's rules for one clock edge using the inputs presented at that edge.
   task automatic model_edge();
      if (!i_clear && i_valid) begin
         if (!m_half) begin
            m_even = '{w0: i_data0, w1: i_data1};
            m_half = 1'b1;
         end else begin
            exp_q.push_back('{w0: m_even.w0, w1: i_data0});
            exp_q.push_back('{w0: m_even.w1, w1: i_data1});
            m_groups++;
            m_half = 1'b0;
         end
      end else if (i_clear) begin
         m_half = 1'b0;
      end
      m_valid = 1'b0;
      if (exp_q.size() > 0) begin
         m_last  = exp_q.pop_front();
         m_valid = 1'b1;
      end
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".valid"}, 64'(o_valid), 64'(m_valid));
      check_val({tag, ".d0"}, o_data0, m_last.w0);
      check_val({tag, ".d1"}, o_data1, m_last.w1);
      check_val({tag, ".phase"}, 64'(o_phase), 64'(m_half));
      check_val({tag, ".cnt"}, 64'(o_grp_cnt), 64'(m_groups % (1 << CW)));
   endtask

   task automatic cycle(input string tag, input logic clr, input logic v,
                        input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      i_clear = clr;
      i_valid = v;
      i_data0 = d0;
      i_data1 = d1;
      @(posedge clk);
      model_edge();
      #1;
      check_outputs(tag);
      if (o_valid) begin
         vcount++;
         out_q.push_back('{w0: o_data0, w1: o_data1});
      end
      i_clear = 1'b0;
      i_valid = 1'b0;
   endtask

   task automatic idle(input string tag, input int n);
      for (int k = 0; k < n; k++) cycle(tag, 1'b0, 1'b0, $urandom, $urandom);
   endtask

   // Asynchronous pulse placed between edges; released before the next posedge.
   task automatic pulse_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] x0, x1, y0, y1;
      logic [CW-1:0] cnt_seq [5];
      pair_t         ref_q[$];
      int            rt_bad;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("reset");
      @(posedge clk);
      #1 check_outputs("reset_held");
      #3 rst_n = 1'b1;

      // Back-to-back groups; first beat lands on the first edge after reset release
      vcount = 0;
      out_q.delete();
      cycle("b2b", 1'b0, 1'b1, 64'd1, 64'd2);
      cycle("b2b", 1'b0, 1'b1, 64'd3, 64'd4);
      check_val("b2b_first", {o_data1, o_data0}, {64'd3, 64'd1});
      cycle("b2b", 1'b0, 1'b1, 64'd5, 64'd6);
      check_val("b2b_second", {o_data1, o_data0}, {64'd4, 64'd2});
      cycle("b2b", 1'b0, 1'b1, 64'd7, 64'd8);
      cycle("b2b", 1'b0, 1'b0, 64'd0, 64'd0);
      check_val("b2b_fourth", {o_data1, o_data0}, {64'd8, 64'd6});
      idle("b2b_idle", 2);
      check_val("b2b_vcount", 64'(vcount), 64'd4);
      check_val("b2b_cnt", 64'(o_grp_cnt), 64'd2);

      // Gapped group
      pulse_reset("gap_rst");
      vcount = 0;
      cycle("gap", 1'b0, 1'b1, 64'hA, 64'hB);
      for (int k = 0; k < 5; k++) begin
         cycle("gap_idle", 1'b0, 1'b0, 64'hEE, 64'hFF);
         check_val("gap_phase", 64'(o_phase), 64'd1);
      end
      cycle("gap", 1'b0, 1'b1, 64'hC, 64'hD);
      idle("gap_tail", 3);
      check_val("gap_vcount", 64'(vcount), 64'd2);

      // Clear mid-group
      pulse_reset("clr_rst");
      vcount = 0;
      cycle("clr", 1'b0, 1'b1, 64'd1, 64'd2);
      cycle("clr", 1'b1, 1'b0, 64'd0, 64'd0);
      cycle("clr", 1'b0, 1'b1, 64'd3, 64'd4);
      cycle("clr", 1'b0, 1'b1, 64'd5, 64'd6);
      idle("clr_tail", 2);
      check_val("clr_vcount", 64'(vcount), 64'd2);
      check_val("clr_cnt", 64'(o_grp_cnt), 64'd1);

      // Clear with a beat present, in the cycle carrying the pending second output
      cycle("clrp", 1'b0, 1'b1, 64'd11, 64'd12);
      cycle("clrp", 1'b0, 1'b1, 64'd13, 64'd14);
      cycle("clrp", 1'b1, 1'b1, 64'd15, 64'd16);
      check_val("clrp_pend", {o_data1, o_data0}, {64'd14, 64'd12});
      idle("clrp_tail", 2);

      // Async reset between odd beat and second output beat
      pulse_reset("ar_rst");
      cycle("ar", 1'b0, 1'b1, 64'd21, 64'd22);
      cycle("ar", 1'b0, 1'b1, 64'd23, 64'd24);
      pulse_reset("ar_mid");
      check_val("ar_zero", {64'(o_valid), o_data0, o_data1}, '0);
      idle("ar_after", 2);

      // Counter wrap with CW=2
      pulse_reset("wrap_rst");
      cnt_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int g = 0; g < 5; g++) begin
         cycle("wrap", 1'b0, 1'b1, $urandom, $urandom);
         cycle("wrap", 1'b0, 1'b1, $urandom, $urandom);
         check_val("wrap_seq", 64'(o_grp_cnt), 64'(cnt_seq[g]));
      end
      idle("wrap_tail", 2);

      // Randomized traffic with occasional clear and async reset
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) pulse_reset("rnd_rst");
         cycle("rnd", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7),
               {$urandom, $urandom}, {$urandom, $urandom});
      end
      idle("rnd_tail", 2);

      // Round trip: swapped stream in, original stream out
      pulse_reset("rt_rst");
      out_q.delete();
      ref_q.delete();
      for (int g = 0; g < 500; g++) begin
         x0 = {$urandom, $urandom};
         x1 = {$urandom, $urandom};
         y0 = {$urandom, $urandom};
         y1 = {$urandom, $urandom};
         ref_q.push_back('{w0: x0, w1: x1});
         ref_q.push_back('{w0: y0, w1: y1});
         cycle("rt", 1'b0, 1'b1, x0, y0);
         cycle("rt", 1'b0, 1'b1, x1, y1);
      end
      idle("rt_tail", 2);
      check_val("rt_len", 64'(out_q.size()), 64'(ref_q.size()));
      rt_bad = 0;
      for (int k = 0; k < ref_q.size() && k < out_q.size(); k++) begin
         if (out_q[k] !== ref_q[k]) rt_bad++;
      end
      check_val("rt_stream", 64'(rt_bad), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
